dds_wave_gen: RTL and testbench

- DDS phase-accumulator and waveform synthesis stage.
- Sits directly downstream of the key-driven waveform selector and consumes its 2-bit wave code.
- Produces an unsigned offset-binary sample every clock for the DAC driver: sine (parabolic approximation), triangle, sawtooth or square.
- Frequency word and phase offset are loadable at run time.

---
 rtl/dds_wave_gen.sv | 129 ++++++++++++
 tb/tb_dds_wave_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// DDS phase accumulator with sine (parabolic), triangle, sawtooth and square shaping.
// Define WAVE_SYNC_SWITCH_EN to defer waveform changes to the next phase wrap.
module dds_wave_gen #(
  parameter int unsigned        PHASE_W   = 32,
  parameter int unsigned        DATA_W    = 8,
  parameter logic [PHASE_W-1:0] FWORD_RST = PHASE_W'(85899)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         wave_c,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [9:0]         phase_off,
  output logic [DATA_W-1:0]  wave_out,
  output logic               wave_vld,
  output logic               cycle_pulse
);

  localparam logic [16:0]       MID     = 17'd1 << (DATA_W - 1);
  localparam logic [16:0]       FULL    = (17'd1 << DATA_W) - 17'd1;
  localparam logic [DATA_W-1:0] MID_OUT = DATA_W'(MID);
  localparam int unsigned       SINE_SH = 17 - DATA_W;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fword_r;
  logic               v1, c1, v2, c2;
  logic [9:0]         p;
  logic [1:0]         wave_act;

`ifdef WAVE_SYNC_SWITCH_EN
  typedef enum logic {StRun, StPend} state_e;
  state_e     state;
  logic [1:0] wave_nxt;
`endif

  logic [PHASE_W:0]  acc_sum;
  logic [9:0]        addr;
  logic [8:0]        x;
  logic [8:0]        tri_t;
  logic [16:0]       sine_y, sine_h, sine_hi, sine_lo;
  logic [15:0]       saw_w, tri_w;
  logic [DATA_W-1:0] shape;

  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, fword_r};
    addr    = acc[PHASE_W-1 -: 10] + phase_off;
    x       = p[8:0];
    tri_t   = p[9] ? ~x : x;
    // x*(512-x) peaks at exactly 2^16 for x = 256, so 17 bits suffice.
    sine_y  = {8'd0, x} * (17'd512 - {8'd0, x});
    sine_h  = sine_y >> SINE_SH;
    sine_hi = MID + sine_h;
    if (sine_hi > FULL) begin
      sine_hi = FULL;
    end
    sine_lo = MID - sine_h;
    // Left-justify in 16 bits so narrow and wide DATA_W share one path.
    saw_w   = {p, 6'd0};
    tri_w   = {tri_t, 7'd0};
    case (wave_act)
      2'b00:   shape = p[9] ? DATA_W'(sine_lo) : DATA_W'(sine_hi);
      2'b01:   shape = DATA_W'(tri_w >> (16 - DATA_W));
      2'b10:   shape = DATA_W'(saw_w >> (16 - DATA_W));
      default: shape = p[9] ? '0 : '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      fword_r     <= FWORD_RST;
      v1          <= 1'b0;
      c1          <= 1'b0;
      v2          <= 1'b0;
      c2          <= 1'b0;
      p           <= '0;
      wave_act    <= 2'b00;
      wave_out    <= MID_OUT;
      wave_vld    <= 1'b0;
      cycle_pulse <= 1'b0;
`ifdef WAVE_SYNC_SWITCH_EN
      state       <= StRun;
      wave_nxt    <= 2'b00;
`endif
    end else begin
      if (freq_load) begin
        fword_r <= freq_word;
      end
      if (enable) begin
        acc <= acc_sum[PHASE_W-1:0];
        v1  <= 1'b1;
        c1  <= acc_sum[PHASE_W];
      end else begin
        v1  <= 1'b0;
        c1  <= 1'b0;
      end
      p           <= addr;
      v2          <= v1;
      c2          <= c1;
      wave_out    <= shape;
      wave_vld    <= v2;
      cycle_pulse <= c2;
`ifdef WAVE_SYNC_SWITCH_EN
      case (state)
        StRun: begin
          if (wave_c != wave_act) begin
            wave_nxt <= wave_c;
            state    <= StPend;
          end
        end
        StPend: begin
          // Switch on the wrap sample, or at once when no wrap can come.
          if (c2 || !enable) begin
            wave_act <= wave_nxt;
            state    <= StRun;
          end else begin
            wave_nxt <= wave_c;
          end
        end
        default: state <= StRun;
      endcase
`else
      wave_act <= wave_c;
`endif
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Bench for dds_wave_gen: hand-computed vector table, corner sequences and
// randomized stimulus checked against an arithmetic reference model.
module tb_dds_wave_gen;

  localparam int unsigned   PW   = 12;
  localparam int unsigned   DW   = 8;
  localparam logic [PW-1:0] FRST = 12'd3;
`ifdef WAVE_SYNC_SWITCH_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    wave_c;
  logic [PW-1:0] freq_word;
  logic          freq_load;
  logic [9:0]    phase_off;
  logic [DW-1:0] wave_out;
  logic          wave_vld;
  logic          cycle_pulse;

  int errors = 0;
  int checks = 0;

  dds_wave_gen #(
    .PHASE_W  (PW),
    .DATA_W   (DW),
    .FWORD_RST(FRST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wave_c     (wave_c),
    .freq_word  (freq_word),
    .freq_load  (freq_load),
    .phase_off  (phase_off),
    .wave_out   (wave_out),
    .wave_vld   (wave_vld),
    .cycle_pulse(cycle_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state: phase, word, selected shape, and 2-edge delay of samples.
  int m_acc, m_fw, m_act, m_nxt, p_d1;
  bit m_pend, en_d1, en_d2, wr_d1, wr_d2;
  int e_out;
  bit e_vld, e_pulse;

  function automatic int shape_ref(int p, int w);
    int x;
    int h;
    x = p % 512;
    case (w)
      0: begin
        h = (x * (512 - x)) / 512;
        if (p < 512) return (128 + h > 255) ? 255 : 128 + h;
        return 128 - h;
      end
      1: return ((p < 512) ? x : 511 - x) / 2;
      2: return p / 4;
      default: return (p < 512) ? 255 : 0;
    endcase
  endfunction

  task automatic model_edge();
    int sum;
    bit pulse_now;
    if (rst) begin
      m_acc = 0; m_fw = int'(FRST); m_act = 0; m_nxt = 0; m_pend = 1'b0; p_d1 = 0;
      en_d1 = 1'b0; en_d2 = 1'b0; wr_d1 = 1'b0; wr_d2 = 1'b0;
      e_out = 128; e_vld = 1'b0; e_pulse = 1'b0;
    end else begin
      pulse_now = wr_d2;
      e_out   = shape_ref(p_d1, m_act);
      e_vld   = en_d2;
      e_pulse = wr_d2;
      if (SYNC) begin
        if (m_pend) begin
          if (pulse_now || !enable) begin
            m_act = m_nxt;
            m_pend = 1'b0;
          end else begin
            m_nxt = int'(wave_c);
          end
        end else if (int'(wave_c) != m_act) begin
          m_nxt = int'(wave_c);
          m_pend = 1'b1;
        end
      end else begin
        m_act = int'(wave_c);
      end
      p_d1  = ((m_acc / 4) + int'(phase_off)) % 1024;
      en_d2 = en_d1;
      wr_d2 = wr_d1;
      if (enable) begin
        sum   = m_acc + m_fw;
        wr_d1 = (sum >= 4096);
        m_acc = sum % 4096;
        en_d1 = 1'b1;
      end else begin
        en_d1 = 1'b0;
        wr_d1 = 1'b0;
      end
      if (freq_load) m_fw = int'(freq_word);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_wave_out", int'(wave_out), e_out);
    check("model_wave_vld", int'(wave_vld), int'(e_vld));
    check("model_cycle_pulse", int'(cycle_pulse), int'(e_pulse));
  endtask

  typedef struct {
    logic [1:0] wave;
    int         fw;
    int         off;
    int         n;
    int         exp_out;
    int         exp_pulse;
  } vec_t;

  vec_t tbl[13];
  bit   found;

  initial begin
    tbl[0]  = '{2'd2, 4,   0,    100, 25,  0};
    tbl[1]  = '{2'd2, 64,  0,    64,  0,   1};
    tbl[2]  = '{2'd3, 4,   0,    1,   255, 0};
    tbl[3]  = '{2'd3, 4,   512,  1,   0,   0};
    tbl[4]  = '{2'd0, 256, 0,    4,   255, 0};
    tbl[5]  = '{2'd0, 256, 0,    12,  0,   0};
    tbl[6]  = '{2'd0, 256, 0,    16,  128, 1};
    tbl[7]  = '{2'd0, 256, 0,    8,   128, 0};
    tbl[8]  = '{2'd0, 128, 0,    4,   224, 0};
    tbl[9]  = '{2'd1, 4,   0,    100, 50,  0};
    tbl[10] = '{2'd1, 4,   600,  100, 161, 0};
    tbl[11] = '{2'd2, 4,   1000, 100, 19,  0};
    tbl[12] = '{2'd0, 36,  0,    100, 35,  0};

    rst = 1'b1; enable = 1'b0; wave_c = 2'd0; freq_word = '0; freq_load = 1'b0;
    phase_off = '0;

    // Reset state.
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_wave_out", int'(wave_out), 128);
    check("rst_wave_vld", int'(wave_vld), 0);
    check("rst_cycle_pulse", int'(cycle_pulse), 0);

    // Table: run n enabled edges from acc=0, then let the pipeline drain.
    for (int i = 0; i < 13; i++) begin
      rst = 1'b1; wave_c = tbl[i].wave; enable = 1'b0;
      step();
      rst = 1'b0; freq_load = 1'b1; freq_word = 12'(tbl[i].fw);
      step();
      freq_load = 1'b0;
      step();
      step();
      phase_off = 10'(tbl[i].off); enable = 1'b1;
      repeat (tbl[i].n) step();
      enable = 1'b0;
      step();
      step();
      check($sformatf("tbl%0d_out", i), int'(wave_out), tbl[i].exp_out);
      check($sformatf("tbl%0d_pulse", i), int'(cycle_pulse), tbl[i].exp_pulse);
      check($sformatf("tbl%0d_vld", i), int'(wave_vld), 1);
    end

    // Deferred switch sine -> triangle mid-period.
    rst = 1'b1; wave_c = 2'd0; phase_off = '0; enable = 1'b0;
    step();
    rst = 1'b0; freq_load = 1'b1; freq_word = 12'd256;
    step();
    freq_load = 1'b0; enable = 1'b1;
    repeat (5) step();
    wave_c = 2'd1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (cycle_pulse) begin
        found = 1'b1;
        check("switch_wrap_sample", int'(wave_out), SYNC ? 128 : 0);
        step();
        check("switch_next_sample", int'(wave_out), 32);
      end
    end
    check("switch_wrap_seen", int'(found), 1);

    // Frequency reload mid-run, then enable drop.
    freq_load = 1'b1; freq_word = 12'd4; wave_c = 2'd2;
    step();
    freq_load = 1'b0;
    repeat (20) step();
    freq_load = 1'b1; freq_word = 12'd8;
    step();
    freq_load = 1'b0;
    repeat (20) step();
    enable = 1'b0;
    step();
    check("drop_vld_e1", int'(wave_vld), 1);
    step();
    check("drop_vld_e2", int'(wave_vld), 1);
    step();
    check("drop_vld_e3", int'(wave_vld), 0);
    repeat (4) step();

    // Zero frequency word: acc frozen, valid follows enable.
    freq_load = 1'b1; freq_word = '0; enable = 1'b1;
    step();
    freq_load = 1'b0;
    repeat (10) step();
    check("fw0_vld", int'(wave_vld), 1);
    check("fw0_pulse", int'(cycle_pulse), 0);

    // Reset while a switch is pending.
    freq_load = 1'b1; freq_word = 12'd40;
    step();
    freq_load = 1'b0; wave_c = 2'd3;
    repeat (3) step();
    rst = 1'b1; wave_c = 2'd0;
    step();
    rst = 1'b0;
    repeat (120) step();

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 9) < 8);
      freq_load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       freq_word = '0;
        1:       freq_word = 12'($urandom_range(1, 15));
        2:       freq_word = 12'($urandom_range(0, 4095));
        default: freq_word = 12'd4095;
      endcase
      if ($urandom_range(0, 29) == 0) wave_c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) phase_off = 10'($urandom_range(0, 1023));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
